// File: rtl/bus_rr_arbiter_if.sv
// Bus arbitration interface for the four-master shared system bus.
// All request, grant, strobe and ready lines are active low, as on the bus.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding bus logic that drives requests, strobe and ready.
interface bus_rr_arbiter_if;
  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  logic       s_as_;
  logic       m_rdy_;
  logic       bus_busy;
  logic [1:0] owner;
  logic       timeout_err;
  logic [1:0] timeout_id;

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    output bus_busy, owner, timeout_err, timeout_id
  );

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, s_as_, m_rdy_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    input  bus_busy, owner, timeout_err, timeout_id
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter for four masters with a tenure limit and a
// transaction watchdog. Grants are active low, registered, and at most one
// is low at any time. A handoff between masters has no dead cycle. A
// watchdog abort inserts one cycle with no grant and pulses timeout_err.
module bus_rr_arbiter #(
  parameter int CNT_W      = 8,
  parameter int MAX_TENURE = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            reset,
  bus_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] TENURE_LIM = CNT_W'(MAX_TENURE);
  localparam logic [CNT_W-1:0] WDOG_LIM   = CNT_W'(TIMEOUT);
  localparam bit               PREEMPT_EN = (MAX_TENURE != 0);

  state_t           r_state;
  logic [3:0]       r_grntN;
  logic             r_busy;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_tenure;
  logic [CNT_W-1:0] r_wdog;
  logic             r_toErr;
  logic [1:0]       r_toId;

  logic [3:0]       w_req;
  logic [3:0]       w_others;
  logic [1:0]       w_pick;
  logic             w_stall;
  logic [CNT_W-1:0] w_wdogInc;
  logic [CNT_W-1:0] w_tenureInc;
  logic             w_timeout;
  logic             w_release;
  logic             w_preempt;

  // Returns the first requester after 'base', wrapping modulo 4.
  // 'base' itself is searched last, so it has the lowest priority.
  function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    rrPick = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) begin
        rrPick = idx;
      end
    end
  endfunction

  // Decodes requests, the round-robin pick and the release, preempt and
  // timeout conditions. While a grant is held r_last equals r_owner, so a
  // single pick from r_last serves both the idle search and the handoff.
  always_comb begin
    w_req       = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
    w_others    = w_req & ~(4'b0001 << r_owner);
    w_pick      = rrPick(w_req, r_last);
    w_stall     = ~bus.s_as_ & bus.m_rdy_;
    w_wdogInc   = r_wdog + CNT_W'(1);
    w_tenureInc = (r_tenure == '1) ? r_tenure : r_tenure + CNT_W'(1);
    w_timeout   = w_stall && (w_wdogInc >= WDOG_LIM);
    w_release   = ~w_req[r_owner];
    w_preempt   = PREEMPT_EN && (w_tenureInc >= TENURE_LIM) && bus.s_as_ && (|w_others);
  end

  // Arbitration FSM. Grants, busy flag, owner and timeout reporting are all
  // registered here, so they change together. Timeout takes priority over
  // release. A release that coincides with tenure expiry is an ordinary
  // release. Preemption is impossible while the strobe is active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_grntN  <= 4'hF;
      r_busy   <= 1'b0;
      r_owner  <= 2'd0;
      r_last   <= 2'd3;
      r_tenure <= '0;
      r_wdog   <= '0;
      r_toErr  <= 1'b0;
      r_toId   <= 2'd0;
    end else begin
      r_toErr <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_ABORT: begin
          r_tenure <= '0;
          r_wdog   <= '0;
          if (|w_req) begin
            r_grntN <= ~(4'b0001 << w_pick);
            r_busy  <= 1'b1;
            r_owner <= w_pick;
            r_last  <= w_pick;
            r_state <= ST_GRANT;
          end else begin
            r_grntN <= 4'hF;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_timeout) begin
            r_grntN  <= 4'hF;
            r_busy   <= 1'b0;
            r_toErr  <= 1'b1;
            r_toId   <= r_owner;
            r_last   <= r_owner;
            r_tenure <= '0;
            r_wdog   <= '0;
            r_state  <= ST_ABORT;
          end else if (w_release || w_preempt) begin
            r_tenure <= '0;
            r_wdog   <= '0;
            if (|w_others) begin
              r_grntN <= ~(4'b0001 << w_pick);
              r_busy  <= 1'b1;
              r_owner <= w_pick;
              r_last  <= w_pick;
              r_state <= ST_GRANT;
            end else begin
              r_grntN <= 4'hF;
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_tenure <= w_tenureInc;
            r_wdog   <= w_stall ? w_wdogInc : '0;
          end
        end
        default: begin
          r_grntN <= 4'hF;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m0_grnt_    = r_grntN[0];
  assign bus.m1_grnt_    = r_grntN[1];
  assign bus.m2_grnt_    = r_grntN[2];
  assign bus.m3_grnt_    = r_grntN[3];
  assign bus.bus_busy    = r_busy;
  assign bus.owner       = r_owner;
  assign bus.timeout_err = r_toErr;
  assign bus.timeout_id  = r_toId;

endmodule
